// File: rtl/rifl_tx_retrans_buf.sv
// -----------------------------------------------------------------------------
// rifl_tx_retrans_buf
//
// Transmit-side replay buffer for a RIFL-style link. Encoded frames are
// written in order and then presented downstream. Each frame's ID is its
// modular write position. Frames stay in the buffer until a cumulative ack
// frees them. A retransmission request rewinds the send pointer. The frames
// between the rewind point and the old send pointer are then replayed, and
// out_retrans is high while they go out.
//
// Pointers (all FRAME_ID_WIDTH bits, modular): ack_ptr <= send_ptr <= wr_ptr.
//   [ack_ptr, send_ptr)  sent and waiting for an ack
//   [send_ptr, wr_ptr)   written but not yet sent
//
// Optional feature: define RIFL_TX_RETRANS_CNT_EN to count accepted
// retransmission requests in retrans_cnt (saturating). Without the macro,
// retrans_cnt is tied to zero.
//
// Ports
//   tx_frame_clk       sole clock, rising edge
//   tx_frame_rst_n     asynchronous active-low reset
//   in_payload         encoded frame (payload + 2 flag bits)
//   in_valid/in_ready  input handshake; in_ready = room in the window
//   out_payload/out_id frame at the send pointer and its ID
//   out_valid/out_ready output handshake; out_valid is gated by pause_req
//   out_retrans        presented frame is a replay
//   ack_valid/ack_id   cumulative ack up to and including ack_id
//   retrans_req/retrans_id  rewind the send pointer to retrans_id
//   pause_req          level; holds the output without touching pointers
//   ack_err/retrans_err one-cycle pulses for out-of-window requests
//   occupancy          unacked frames held (wr_ptr - ack_ptr)
//   state              0 = NORMAL, 1 = REPLAY
//   retrans_cnt        accepted retransmission count
// -----------------------------------------------------------------------------
module rifl_tx_retrans_buf #(
  parameter int PAYLOAD_WIDTH  = 240,
  parameter int FRAME_ID_WIDTH = 8,
  parameter int DEPTH          = 16
) (
  input  logic                      tx_frame_clk,
  input  logic                      tx_frame_rst_n,
  input  logic [PAYLOAD_WIDTH+1:0]  in_payload,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [PAYLOAD_WIDTH+1:0]  out_payload,
  output logic [FRAME_ID_WIDTH-1:0] out_id,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_retrans,
  input  logic                      ack_valid,
  input  logic [FRAME_ID_WIDTH-1:0] ack_id,
  input  logic                      retrans_req,
  input  logic [FRAME_ID_WIDTH-1:0] retrans_id,
  input  logic                      pause_req,
  output logic                      ack_err,
  output logic                      retrans_err,
  output logic [FRAME_ID_WIDTH:0]   occupancy,
  output logic                      state,
  output logic [15:0]               retrans_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [FRAME_ID_WIDTH-1:0] ID_ONE   = FRAME_ID_WIDTH'(1);
  localparam logic [FRAME_ID_WIDTH-1:0] DEPTH_ID = FRAME_ID_WIDTH'(DEPTH);

  typedef enum logic {
    NORMAL = 1'b0,
    REPLAY = 1'b1
  } state_t;

  // Frame storage
  logic [PAYLOAD_WIDTH+1:0] mem [DEPTH];

  // Registered state
  logic [FRAME_ID_WIDTH-1:0] wr_ptr;
  logic [FRAME_ID_WIDTH-1:0] send_ptr;
  logic [FRAME_ID_WIDTH-1:0] ack_ptr;
  logic [FRAME_ID_WIDTH-1:0] replay_end;
  state_t                    state_q;

  // Combinational decode
  logic                      in_xfer;
  logic                      out_xfer;
  logic [FRAME_ID_WIDTH-1:0] held;
  logic [FRAME_ID_WIDTH-1:0] ack_off;
  logic [FRAME_ID_WIDTH-1:0] ack_span;
  logic                      ack_ok;
  logic [FRAME_ID_WIDTH-1:0] ack_base;
  logic [FRAME_ID_WIDTH-1:0] rt_off;
  logic [FRAME_ID_WIDTH-1:0] rt_span;
  logic                      retrans_ok;
  logic [FRAME_ID_WIDTH-1:0] send_nxt;
  logic [FRAME_ID_WIDTH-1:0] replay_end_nxt;
  state_t                    state_nxt;

  // Window fill. DEPTH <= 2^(FRAME_ID_WIDTH-1), so the modular difference
  // never aliases and a full buffer (== DEPTH) is representable.
  assign held      = wr_ptr - ack_ptr;
  assign occupancy = {1'b0, held};
  assign in_ready  = (held < DEPTH_ID);
  assign in_xfer   = in_valid & in_ready;

  // Output side reads the frame at the send pointer directly.
  assign out_valid   = (send_ptr != wr_ptr) && !pause_req;
  assign out_payload = mem[send_ptr[IDX_W-1:0]];
  assign out_id      = send_ptr;
  assign out_xfer    = out_valid & out_ready;
  assign out_retrans = (state_q == REPLAY);
  assign state       = state_q;

  // Window membership is tested with offsets from the window base. This
  // keeps the test correct across the ID wrap: id is in [base, send_ptr-1]
  // exactly when (id - base) < (send_ptr - base).
  assign ack_off  = ack_id - ack_ptr;
  assign ack_span = send_ptr - ack_ptr;
  assign ack_ok   = ack_valid && (ack_off < ack_span);
  assign ack_base = ack_ok ? (ack_id + ID_ONE) : ack_ptr;

  // The retrans window starts after any same-cycle ack has been applied.
  assign rt_off     = retrans_id - ack_base;
  assign rt_span    = send_ptr - ack_base;
  assign retrans_ok = retrans_req && (rt_off < rt_span);

  // NOTE: every signal gets a default at the top of the block, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    send_nxt       = send_ptr;
    replay_end_nxt = replay_end;
    state_nxt      = state_q;
    if (retrans_ok) begin
      // A rewind wins over a transfer in the same cycle. On entry to
      // REPLAY, the replay ends at the pre-transfer send pointer. A second
      // rewind during REPLAY keeps the original end.
      send_nxt = retrans_id;
      if (state_q == NORMAL) begin
        replay_end_nxt = send_ptr;
        state_nxt      = REPLAY;
      end
    end else if (out_xfer) begin
      send_nxt = send_ptr + ID_ONE;
      if ((state_q == REPLAY) && ((send_ptr + ID_ONE) == replay_end)) begin
        state_nxt = NORMAL;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. All
  // registers then update together on the edge, whatever order the
  // statements are in.
  always_ff @(posedge tx_frame_clk or negedge tx_frame_rst_n) begin
    if (!tx_frame_rst_n) begin
      wr_ptr      <= '0;
      send_ptr    <= '0;
      ack_ptr     <= '0;
      replay_end  <= '0;
      state_q     <= NORMAL;
      ack_err     <= 1'b0;
      retrans_err <= 1'b0;
    end else begin
      if (in_xfer) begin
        wr_ptr <= wr_ptr + ID_ONE;
      end
      ack_ptr     <= ack_base;
      send_ptr    <= send_nxt;
      replay_end  <= replay_end_nxt;
      state_q     <= state_nxt;
      ack_err     <= ack_valid && !ack_ok;
      retrans_err <= retrans_req && !retrans_ok;
    end
  end

  // NOTE: the frame array has no reset. After reset, nothing is readable
  // until it has been written, so clearing it would only add reset fan-out.
  always_ff @(posedge tx_frame_clk) begin
    if (in_xfer) begin
      mem[wr_ptr[IDX_W-1:0]] <= in_payload;
    end
  end

`ifdef RIFL_TX_RETRANS_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge tx_frame_clk or negedge tx_frame_rst_n) begin
    if (!tx_frame_rst_n) begin
      cnt_q <= '0;
    end else if (retrans_ok && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign retrans_cnt = cnt_q;
`else
  assign retrans_cnt = '0;
`endif

endmodule

// File: tb/tb_rifl_tx_retrans_buf.sv
// -----------------------------------------------------------------------------
// tb_rifl_tx_retrans_buf
//
// Directed bench for rifl_tx_retrans_buf at its default parameters
// (242-bit word, 8-bit IDs, 16 entries). Each call to drive() is one clock
// cycle. Inputs are applied after the falling edge, and outputs are sampled
// 1 ns later, before the next rising edge. The bench keeps its own copy of
// every payload it pushes, indexed by frame ID, and compares out_payload
// against that copy.
// -----------------------------------------------------------------------------
module tb_rifl_tx_retrans_buf;

  localparam int W = 242;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  in_payload;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_payload;
  logic [7:0]    out_id;
  logic          out_valid;
  logic          out_ready;
  logic          out_retrans;
  logic          ack_valid;
  logic [7:0]    ack_id;
  logic          retrans_req;
  logic [7:0]    retrans_id;
  logic          pause_req;
  logic          ack_err;
  logic          retrans_err;
  logic [8:0]    occupancy;
  logic          state;
  logic [15:0]   retrans_cnt;

  rifl_tx_retrans_buf dut (
    .tx_frame_clk   (clk),
    .tx_frame_rst_n (rst_n),
    .in_payload     (in_payload),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_payload    (out_payload),
    .out_id         (out_id),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_retrans    (out_retrans),
    .ack_valid      (ack_valid),
    .ack_id         (ack_id),
    .retrans_req    (retrans_req),
    .retrans_id     (retrans_id),
    .pause_req      (pause_req),
    .ack_err        (ack_err),
    .retrans_err    (retrans_err),
    .occupancy      (occupancy),
    .state          (state),
    .retrans_cnt    (retrans_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] model_mem [256];
  logic [7:0]   push_id = 8'd0;
  int unsigned  seq     = 0;

  // One cycle of stimulus plus expected outputs, all held as ints.
  typedef struct {
    int iv, ordy, av, aid, rr, rid, pz;
    int ov, oid, ort, ir, occ, ae, re, st;
  } vec_t;

  vec_t tbl [30];

  function automatic logic [W-1:0] make_payload(input int unsigned s);
    logic [W-1:0] r;
    logic [31:0]  h;
    r = '0;
    for (int k = 0; k < W; k++) begin
      h    = s * 32'h9E37_79B1 + 32'(k / 32) * 32'h85EB_CA6B;
      r[k] = h[k % 32];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Apply one cycle of inputs after the falling edge, then let it settle.
  task automatic drive(input int iv, input int ordy, input int av,
                       input int aid, input int rr, input int rid,
                       input int pz);
    @(negedge clk);
    in_valid    = 1'(iv);
    out_ready   = 1'(ordy);
    ack_valid   = 1'(av);
    ack_id      = 8'(aid);
    retrans_req = 1'(rr);
    retrans_id  = 8'(rid);
    pause_req   = 1'(pz);
    in_payload  = make_payload(seq);
    if (iv != 0) begin
      model_mem[push_id] = in_payload;
      push_id++;
      seq++;
    end
    #1;
  endtask

  task automatic check_outs(input string tag, input int ov, input int oid,
                            input int ort, input int ir, input int occ,
                            input int ae, input int re, input int st);
    check({tag, " out_valid"},   W'(out_valid),   W'(ov));
    check({tag, " out_id"},      W'(out_id),      W'(oid));
    check({tag, " out_retrans"}, W'(out_retrans), W'(ort));
    check({tag, " in_ready"},    W'(in_ready),    W'(ir));
    check({tag, " occupancy"},   W'(occupancy),   W'(occ));
    check({tag, " ack_err"},     W'(ack_err),     W'(ae));
    check({tag, " retrans_err"}, W'(retrans_err), W'(re));
    check({tag, " state"},       W'(state),       W'(st));
    if (ov != 0) begin
      check({tag, " out_payload"}, out_payload, model_mem[8'(oid)]);
    end
  endtask

  task automatic reset_dut(input string tag);
    @(negedge clk);
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    ack_valid   = 1'b0;
    ack_id      = 8'd0;
    retrans_req = 1'b0;
    retrans_id  = 8'd0;
    pause_req   = 1'b0;
    #1;
    check_outs({tag, " in-reset"}, 0, 0, 0, 1, 0, 0, 0, 0);
    check({tag, " retrans_cnt"}, W'(retrans_cnt), W'(0));
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    push_id = 8'd0;
    #1;
    check_outs({tag, " released"}, 0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_cnt;

    // Scenario rows. Columns:
    //   iv ordy av aid rr rid pz | ov oid ort ir occ ae re st
    // Rows 0..8: stream frames 0..8 through; 0..7 go out.
    tbl[0] = '{1,1,0,0,0,0,0,  0,0,0,1,0,0,0,0};
    for (int k = 1; k <= 8; k++) begin
      tbl[k] = '{1,1,0,0,0,0,0,  1,k-1,0,1,k,0,0,0};
    end
    // ack 1 and rewind to 4 in the same cycle; replay 4..7, then frame 8.
    tbl[9]  = '{0,0,1,1,1,4,0,  1,8,0,1,9,0,0,0};
    tbl[10] = '{0,1,0,0,0,0,0,  1,4,1,1,7,0,0,1};
    tbl[11] = '{0,1,0,0,0,0,0,  1,5,1,1,7,0,0,1};
    tbl[12] = '{0,1,0,0,0,0,0,  1,6,1,1,7,0,0,1};
    tbl[13] = '{0,1,0,0,0,0,0,  1,7,1,1,7,0,0,1};
    tbl[14] = '{0,1,0,0,0,0,0,  1,8,0,1,7,0,0,0};
    // ack 5 with a rewind to 3: ack applies, 3 is now below the window.
    tbl[15] = '{0,0,1,5,1,3,0,  0,9,0,1,7,0,0,0};
    tbl[16] = '{0,0,0,0,0,0,0,  0,9,0,1,3,0,1,0};
    tbl[17] = '{1,0,0,0,0,0,0,  0,9,0,1,3,0,0,0};
    tbl[18] = '{1,0,0,0,0,0,0,  1,9,0,1,4,0,0,0};
    // Rewind to 7 overriding the transfer of 9, then a rewind to 6 in
    // REPLAY overriding the transfer of 7; replay ends at 9.
    tbl[19] = '{0,1,0,0,1,7,0,  1,9,0,1,5,0,0,0};
    tbl[20] = '{0,1,0,0,1,6,0,  1,7,1,1,5,0,0,1};
    tbl[21] = '{0,1,0,0,0,0,0,  1,6,1,1,5,0,0,1};
    tbl[22] = '{0,1,0,0,0,0,0,  1,7,1,1,5,0,0,1};
    tbl[23] = '{0,1,0,0,0,0,0,  1,8,1,1,5,0,0,1};
    tbl[24] = '{0,1,0,0,0,0,0,  1,9,0,1,5,0,0,0};
    tbl[25] = '{0,1,0,0,0,0,0,  1,10,0,1,5,0,0,0};
    // Ack at send_ptr (not yet sent) and rewind below ack_ptr both error.
    tbl[26] = '{0,0,1,11,0,0,0, 0,11,0,1,5,0,0,0};
    tbl[27] = '{0,0,0,0,1,5,0,  0,11,0,1,5,1,0,0};
    tbl[28] = '{0,0,1,10,0,0,0, 0,11,0,1,5,0,1,0};
    tbl[29] = '{0,0,0,0,0,0,0,  0,11,0,1,0,0,0,0};

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    ack_valid   = 1'b0;
    ack_id      = 8'd0;
    retrans_req = 1'b0;
    retrans_id  = 8'd0;
    pause_req   = 1'b0;
    in_payload  = '0;

    reset_dut("reset0");

    // Fill all 16 entries while sending, no acks.
    for (int i = 0; i <= 16; i++) begin
      drive((i < 16) ? 1 : 0, 1, 0, 0, 0, 0, 0);
      check_outs($sformatf("fill%0d", i), (i > 0) ? 1 : 0,
                 (i > 0) ? i - 1 : 0, 0, (i < 16) ? 1 : 0, i, 0, 0, 0);
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    check_outs("full", 0, 16, 0, 0, 16, 0, 0, 0);
    drive(0, 0, 1, 9, 0, 0, 0);
    check_outs("ack9 issue", 0, 16, 0, 0, 16, 0, 0, 0);
    drive(0, 0, 1, 3, 0, 0, 0);
    check_outs("ack9 applied", 0, 16, 0, 1, 6, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check_outs("ack3 err", 0, 16, 0, 1, 6, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check_outs("ack3 err end", 0, 16, 0, 1, 6, 0, 0, 0);

    reset_dut("reset1");

    for (int r = 0; r < 30; r++) begin
      drive(tbl[r].iv, tbl[r].ordy, tbl[r].av, tbl[r].aid,
            tbl[r].rr, tbl[r].rid, tbl[r].pz);
      check_outs($sformatf("row%0d", r), tbl[r].ov, tbl[r].oid, tbl[r].ort,
                 tbl[r].ir, tbl[r].occ, tbl[r].ae, tbl[r].re, tbl[r].st);
    end
`ifdef RIFL_TX_RETRANS_CNT_EN
    exp_cnt = 3;
`else
    exp_cnt = 0;
`endif
    check("retrans_cnt after table", W'(retrans_cnt), W'(exp_cnt));

    // Pause for 10 cycles while frames 11..13 arrive; then release.
    for (int p = 0; p < 10; p++) begin
      drive((p < 3) ? 1 : 0, 1, 0, 0, 0, 0, 1);
      check_outs($sformatf("pause%0d", p), 0, 11, 0, 1, (p < 3) ? p : 3,
                 0, 0, 0);
    end
    for (int j = 0; j < 3; j++) begin
      drive(0, 1, 0, 0, 0, 0, 0);
      check_outs($sformatf("resume%0d", j), 1, 11 + j, 0, 1, 3, 0, 0, 0);
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    check_outs("resume done", 0, 14, 0, 1, 3, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check_outs("pending 14", 1, 14, 0, 1, 4, 0, 0, 0);

    // Reset with a frame waiting on the output: everything is discarded.
    reset_dut("reset2");

    // 300 frames, each acked one cycle after it is sent; IDs wrap.
    for (int i = 0; i <= 300; i++) begin
      drive((i < 300) ? 1 : 0, 1, (i >= 2) ? 1 : 0, (i >= 2) ? i - 2 : 0,
            0, 0, 0);
      check_outs($sformatf("wrap%0d", i), (i > 0) ? 1 : 0,
                 (i > 0) ? (i - 1) % 256 : 0, 0, 1,
                 (i >= 2) ? 2 : i, 0, 0, 0);
    end
    drive(0, 1, 1, 299 % 256, 0, 0, 0);
    check_outs("wrap tail", 0, 300 % 256, 0, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check_outs("wrap drained", 0, 300 % 256, 0, 1, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rifl_tx_retrans_buf.md
RIFL_TX_RETRANS_BUF -- requirements
Module: rifl_tx_retrans_buf

Interface
REQ-001 SHALL have parameter PAYLOAD_WIDTH, default 240: user payload bits; stored word is PAYLOAD_WIDTH+2 (payload plus 2 encode flag bits).
REQ-002 SHALL have parameter FRAME_ID_WIDTH, default 8: frame ID width; all pointers are FRAME_ID_WIDTH bits, modulo 2^FRAME_ID_WIDTH.
REQ-003 SHALL have parameter DEPTH, default 16: replay buffer entries; power of 2, 2..2^(FRAME_ID_WIDTH-1).
REQ-004 tx_frame_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 tx_frame_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 in_payload  in  PAYLOAD_WIDTH+2  encoded frame payload.
REQ-007 in_valid / in_ready  in / out  1  input handshake; transfer when both high.
REQ-008 out_payload  out  PAYLOAD_WIDTH+2  frame at send pointer.
REQ-009 out_id  out  FRAME_ID_WIDTH  ID of out_payload.
REQ-010 out_valid / out_ready  out / in  1  output handshake.
REQ-011 out_retrans  out  1  high while the presented frame is a replay.
REQ-012 ack_valid, ack_id  in  1, FRAME_ID_WIDTH  cumulative ack: frees all frames up to and including ack_id.
REQ-013 retrans_req, retrans_id  in  1, FRAME_ID_WIDTH  rewind request to retrans_id.
REQ-014 pause_req  in  1  level; holds output.
REQ-015 ack_err, retrans_err  out  1  one-cycle pulses for out-of-window requests.
REQ-016 occupancy  out  FRAME_ID_WIDTH+1  unacked frames held (wr-ack).
REQ-017 state  out  1  0=NORMAL, 1=REPLAY.
REQ-018 retrans_cnt  out  16  accepted retransmission count (see Configuration).

Function
REQ-019 SHALL keep three pointers ack_ptr <= send_ptr <= wr_ptr (modular); entry index = pointer mod DEPTH.
REQ-020 in_ready SHALL be (wr_ptr-ack_ptr) < DEPTH, combinational from registers; on input transfer buf[wr_ptr] written, wr_ptr+1.
REQ-021 out_valid SHALL be (send_ptr != wr_ptr) and not pause_req; out_payload = buf[send_ptr], out_id = send_ptr, combinational read; frame accepted at cycle N is presentable at N+1.
REQ-022 On output transfer send_ptr SHALL increment; with out_valid high and out_ready low, out_payload/out_id SHALL stay stable.
REQ-023 Ack accepted iff ack_id in [ack_ptr, send_ptr-1]; then ack_ptr = ack_id+1; otherwise no change and ack_err pulses next cycle.
REQ-024 Retrans accepted iff retrans_id in [ack_ptr, send_ptr-1] after same-cycle ack applied; otherwise retrans_err pulses next cycle.
REQ-025 Accepted retrans in NORMAL: replay_end = send_ptr (pre-transfer value), send_ptr = retrans_id, state -> REPLAY.
REQ-026 Accepted retrans in REPLAY: send_ptr = retrans_id, replay_end unchanged.
REQ-027 Retrans overrides same-cycle output transfer for send_ptr; that transfer is not re-counted.
REQ-028 REPLAY -> NORMAL when an output transfer makes send_ptr == replay_end; out_retrans = (state == REPLAY).
REQ-029 Same-cycle input transfer and ack SHALL both apply; in_ready reflects registered values only.
REQ-030 pause_req SHALL not alter pointers or state; acks, retrans and input writes continue.

Reset
REQ-031 On tx_frame_rst_n low: all pointers 0, replay_end 0, state NORMAL, out_valid 0, in_ready 1, ack_err 0, retrans_err 0, occupancy 0, retrans_cnt 0; buffer contents not reset.
REQ-032 Reset mid-replay or mid-handshake SHALL discard all frames; first frame after release gets ID 0.

Configuration
REQ-033 Macro RIFL_TX_RETRANS_CNT_EN defined: retrans_cnt increments on each accepted retrans, saturating at 16'hFFFF.
REQ-034 Macro undefined: retrans_cnt tied to 0, no counter logic.

Verification
REQ-035 Push 16 frames (DEPTH=16) with out_ready=1, no acks -> IDs 0..15 out in order, in_ready 0, occupancy 16.
REQ-036 After REQ-035, ack_id=9 -> occupancy 6, in_ready 1; ack_id=3 then -> ack_err pulse, no change.
REQ-037 Sent 0..7, ack_id=1, retrans_id=4 -> out IDs 4,5,6,7 with out_retrans=1, then NORMAL, ID 8 with out_retrans=0.
REQ-038 Same cycle ack_id=5, retrans_id=3 -> ack applied, retrans_err pulse, send_ptr unchanged.
REQ-039 Push 300 frames, acking each on send -> IDs wrap 255->0, no errors, data matches.
REQ-040 pause_req high 10 cycles with frames pending -> out_valid 0, out_id unchanged; release -> sequence resumes intact.
